// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game countdown timer.
// Imported by the timer FSM and its prescaler.
package game_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   typedef logic [6:0] count_t;

   localparam int DEFAULT_MAX_COUNT = 99;

endpackage

// File: rtl/game_timer_tick_gen.sv
// One-second prescaler: counts enabled cycles and flags the last one.
// clear has priority over enable so a restart always begins at zero.
module tick_gen #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int W = $clog2(TICKS_PER_SEC);
   localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

   logic [W-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/game_timer.sv
// Countdown timer FSM and count register.
// All outputs are registered; the prescaler lives in tick_gen.
module game_timer
   import game_timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int MAX_COUNT     = DEFAULT_MAX_COUNT
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  count_t load_value,
   input  logic   start,
   input  logic   stop,
   output count_t wholeNum,
   output logic   running,
   output logic   timeout,
   output logic   expired
);

   localparam count_t LIMIT = count_t'(MAX_COUNT);

   state_t state;
   state_t state_n;
   count_t count_n;
   logic   timeout_n;
   logic   clear;
   logic   enable;
   logic   tick;
   logic   go;
   logic   halt;

   // start and stop together cancel each other
   assign go     = start & ~stop;
   assign halt   = stop & ~start;
   assign enable = (state == RUNNING);

   tick_gen #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .enable(enable),
      .tick  (tick)
   );

   always_comb begin
      state_n   = state;
      count_n   = wholeNum;
      timeout_n = 1'b0;
      clear     = 1'b0;
      if (load) begin
         state_n = IDLE;
         count_n = (load_value > LIMIT) ? LIMIT : load_value;
         clear   = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (go && wholeNum != '0) begin
                  state_n = RUNNING;
                  clear   = 1'b1;
               end
            end
            PAUSED: begin
               if (go && wholeNum != '0) begin
                  state_n = RUNNING;
               end
            end
            RUNNING: begin
               // decrement first; reaching zero beats a pause
               if (tick && wholeNum <= count_t'(1)) begin
                  count_n   = '0;
                  state_n   = EXPIRED;
                  timeout_n = 1'b1;
               end else if (tick) begin
                  count_n = wholeNum - count_t'(1);
                  if (halt) state_n = PAUSED;
               end else if (halt) begin
                  state_n = PAUSED;
               end
            end
            EXPIRED: begin
               count_n = '0;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wholeNum <= '0;
         running  <= 1'b0;
         timeout  <= 1'b0;
         expired  <= 1'b0;
      end else begin
         state    <= state_n;
         wholeNum <= count_n;
         running  <= (state_n == RUNNING);
         timeout  <= timeout_n;
         expired  <= (state_n == EXPIRED);
      end
   end

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with a cycle-level reference model.
// Literal checks pin key moments; a compare process checks every cycle.
module tb_game_timer;

   localparam int T   = 4;
   localparam int MAX = 99;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_PAU  = 2;
   localparam int M_EXP  = 3;

   logic       clk;
   logic       rst;
   logic       load;
   logic [6:0] load_value;
   logic       start;
   logic       stop;
   logic [6:0] wholeNum;
   logic       running;
   logic       timeout;
   logic       expired;

   int checks;
   int errors;

   int m_mode;
   int m_count;
   int m_elapsed;
   int m_timeout;

   game_timer #(
      .TICKS_PER_SEC(T),
      .MAX_COUNT    (MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_value(load_value),
      .start     (start),
      .stop      (stop),
      .wholeNum  (wholeNum),
      .running   (running),
      .timeout   (timeout),
      .expired   (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: elapsed = running cycles since the countdown phase was zeroed
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode    = M_IDLE;
         m_count   = 0;
         m_elapsed = 0;
         m_timeout = 0;
      end else begin
         m_timeout = 0;
         if (load) begin
            m_mode    = M_IDLE;
            m_count   = (int'(load_value) > MAX) ? MAX : int'(load_value);
            m_elapsed = 0;
         end else if (m_mode == M_RUN) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed % T == 0) begin
               m_count = m_count - 1;
               if (m_count == 0) begin
                  m_mode    = M_EXP;
                  m_timeout = 1;
               end else if (stop && !start) begin
                  m_mode = M_PAU;
               end
            end else if (stop && !start) begin
               m_mode = M_PAU;
            end
         end else if ((m_mode == M_IDLE || m_mode == M_PAU)
                      && start && !stop && m_count > 0) begin
            if (m_mode == M_IDLE) m_elapsed = 0;
            m_mode = M_RUN;
         end
      end
   end

   always @(negedge clk) begin
      chk("cmp_count", int'(wholeNum), m_count);
      chk("cmp_running", int'(running), int'(m_mode == M_RUN));
      chk("cmp_expired", int'(expired), int'(m_mode == M_EXP));
      chk("cmp_timeout", int'(timeout), m_timeout);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input int v);
      load       = 1'b1;
      load_value = 7'(v);
      step();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b0;
      load       = 1'b0;
      load_value = '0;
      start      = 1'b0;
      stop       = 1'b0;
      step(2);
      chk("rst_count", int'(wholeNum), 0);
      chk("rst_flags", int'({running, timeout, expired}), 0);
      rst = 1'b1;

      // 3 -> 0 at 4-cycle intervals
      do_load(3);
      chk("ld3", int'(wholeNum), 3);
      do_start();
      chk("run3", int'(running), 1);
      step(3);
      chk("hold3", int'(wholeNum), 3);
      step();
      chk("dec2", int'(wholeNum), 2);
      step(4);
      chk("dec1", int'(wholeNum), 1);
      step(4);
      chk("dec0", int'(wholeNum), 0);
      chk("to_pulse", int'(timeout), 1);
      chk("exp_hi", int'(expired), 1);
      step();
      chk("to_gone", int'(timeout), 0);
      chk("exp_hold", int'(expired), 1);
      do_start();
      chk("exp_ign", int'({running, expired}), 1);

      // clamp and zero start
      do_load(120);
      chk("clamp", int'(wholeNum), 99);
      do_load(0);
      do_start();
      chk("zero_st", int'(running), 0);
      step(5);
      chk("zero_cnt", int'(wholeNum), 0);

      // pause and resume
      do_load(5);
      do_start();
      step(5);
      do_stop();
      chk("pau_run", int'(running), 0);
      chk("pau_cnt", int'(wholeNum), 4);
      step(10);
      chk("pau_hold", int'(wholeNum), 4);
      do_start();
      chk("res_run", int'(running), 1);
      step();
      chk("res_hold", int'(wholeNum), 4);
      step();
      chk("res_dec", int'(wholeNum), 3);

      // load beats start
      load       = 1'b1;
      start      = 1'b1;
      load_value = 7'd9;
      step();
      load  = 1'b0;
      start = 1'b0;
      chk("ldst_cnt", int'(wholeNum), 9);
      chk("ldst_run", int'(running), 0);
      do_start();
      chk("ldst_go", int'(running), 1);

      // stop on the final tick
      do_load(1);
      do_start();
      step(3);
      do_stop();
      chk("stx_exp", int'(expired), 1);
      chk("stx_to", int'(timeout), 1);
      chk("stx_run", int'(running), 0);
      step(3);
      chk("stx_hold", int'(expired), 1);

      // async reset mid-count
      do_load(8);
      do_start();
      step(4);
      chk("pre_rst", int'(wholeNum), 7);
      step();
      #2 rst = 1'b0;
      #1;
      chk("arst_cnt", int'(wholeNum), 0);
      chk("arst_flg", int'({running, timeout, expired}), 0);
      step(3);
      rst = 1'b1;
      do_load(12);
      chk("post_ld", int'(wholeNum), 12);
      do_start();
      chk("post_run", int'(running), 1);
      step(6);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
